// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control FSM with a lap-capture FIFO feeding a valid/ready consumer.
// Optional macro LAP_OVERWRITE_EN: a lap into a full FIFO replaces the oldest entry instead of being dropped.
module stopwatch_lap_ctrl #(
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         btn_ss,
    input  logic                         btn_lr,
    input  logic [7:0]                   sw_minutes,
    input  logic [5:0]                   sw_seconds,
    output logic                         sw_start,
    output logic                         sw_stop,
    output logic                         sw_reset,
    output logic [1:0]                   state,
    output logic [13:0]                  lap_data,
    output logic                         lap_valid,
    input  logic                         lap_ready,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_overflow
);
    localparam int PW = $clog2(LAP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [CW-1:0] FULL_CNT = CW'(LAP_DEPTH);

    logic [1:0]    state_r, state_s;
    logic          sw_start_r, sw_stop_r, sw_reset_r;
    logic          start_s, stop_s, swrst_s, flush_s, lap_req_s;
    logic [13:0]   cap_r;
    logic          push_pend_r;
    logic [13:0]   mem_r [LAP_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic [CW-1:0] count_r, count_s;
    logic          valid_r, overflow_r, overflow_s, wr_en_s, push_s, pop_s, full_s;
    logic [13:0]   data_r, data_s, head_s;

    // Button decode: start/stop has priority over lap/reset
    always_comb begin
        state_s   = state_r;
        start_s   = 1'b0;
        stop_s    = 1'b0;
        swrst_s   = 1'b0;
        flush_s   = 1'b0;
        lap_req_s = 1'b0;
        if (btn_ss) begin
            case (state_r)
                ST_IDLE:  begin state_s = ST_RUN;   start_s = 1'b1; end
                ST_RUN:   begin state_s = ST_PAUSE; stop_s  = 1'b1; end
                ST_PAUSE: begin state_s = ST_RUN;   start_s = 1'b1; end
                default:  state_s = ST_IDLE;
            endcase
        end else if (btn_lr) begin
            if (state_r == ST_RUN) begin
                lap_req_s = 1'b1;
            end else begin
                state_s = ST_IDLE;
                swrst_s = 1'b1;
                flush_s = 1'b1;
            end
        end else begin
            state_s = state_r;
        end
    end

    // FIFO pointer/occupancy update; flush beats push and pop
    always_comb begin
        push_s     = push_pend_r;
        pop_s      = valid_r & lap_ready;
        full_s     = (count_r == FULL_CNT);
        wr_en_s    = 1'b0;
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        count_s    = count_r;
        overflow_s = overflow_r;
        if (flush_s) begin
            wr_ptr_s   = {PW{1'b0}};
            rd_ptr_s   = {PW{1'b0}};
            count_s    = {CW{1'b0}};
            overflow_s = 1'b0;
        end else if (push_s && pop_s) begin
            wr_en_s  = 1'b1;
            wr_ptr_s = wr_ptr_r + PW'(1);
            rd_ptr_s = rd_ptr_r + PW'(1);
        end else if (push_s && full_s) begin
            overflow_s = 1'b1;
`ifdef LAP_OVERWRITE_EN
            wr_en_s  = 1'b1;
            wr_ptr_s = wr_ptr_r + PW'(1);
            rd_ptr_s = rd_ptr_r + PW'(1);
`else
            wr_en_s  = 1'b0;
`endif
        end else if (push_s) begin
            wr_en_s  = 1'b1;
            wr_ptr_s = wr_ptr_r + PW'(1);
            count_s  = count_r + CW'(1);
        end else if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PW'(1);
            count_s  = count_r - CW'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Next head: bypass the entry being written when it lands in the head slot
    always_comb begin
        if (wr_en_s && (wr_ptr_r == rd_ptr_s)) begin
            head_s = cap_r;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
        if (count_s != {CW{1'b0}}) begin
            data_s = head_s;
        end else begin
            data_s = 14'd0;
        end
    end

    // Control and FIFO state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sw_start_r  <= 1'b0;
            sw_stop_r   <= 1'b0;
            sw_reset_r  <= 1'b0;
            cap_r       <= 14'd0;
            push_pend_r <= 1'b0;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            valid_r     <= 1'b0;
            overflow_r  <= 1'b0;
            data_r      <= 14'd0;
        end else begin
            state_r     <= state_s;
            sw_start_r  <= start_s;
            sw_stop_r   <= stop_s;
            sw_reset_r  <= swrst_s;
            cap_r       <= lap_req_s ? {sw_minutes, sw_seconds} : cap_r;
            push_pend_r <= lap_req_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            valid_r     <= (count_s != {CW{1'b0}});
            overflow_r  <= overflow_s;
            data_r      <= data_s;
        end
    end

    // Lap storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            mem_r[wr_ptr_r] <= cap_r;
        end
    end

    assign sw_start     = sw_start_r;
    assign sw_stop      = sw_stop_r;
    assign sw_reset     = sw_reset_r;
    assign state        = state_r;
    assign lap_data     = data_r;
    assign lap_valid    = valid_r;
    assign lap_count    = count_r;
    assign lap_overflow = overflow_r;
endmodule

// File: doc/stopwatch_lap_ctrl.md
STOPWATCH_LAP_CTRL -- requirements
Module: stopwatch_lap_ctrl

Interface
REQ-001 The block SHALL have parameter LAP_DEPTH, default 4, giving lap FIFO entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low; ports are named clk and rst_n.
REQ-003 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port btn_ss, input, 1 bit: debounced single-cycle start/stop request.
REQ-006 The block SHALL have port btn_lr, input, 1 bit: debounced single-cycle lap/reset request.
REQ-007 The block SHALL have port sw_minutes, input, 8 bits: the stopwatch minutes value.
REQ-008 The block SHALL have port sw_seconds, input, 6 bits: the stopwatch seconds value.
REQ-009 The block SHALL have port sw_start, output, 1 bit: one-cycle start pulse to the stopwatch.
REQ-010 The block SHALL have port sw_stop, output, 1 bit: one-cycle stop pulse to the stopwatch.
REQ-011 The block SHALL have port sw_reset, output, 1 bit: one-cycle reset pulse to the stopwatch.
REQ-012 The block SHALL have port state, output, 2 bits: 00 IDLE, 01 RUNNING, 10 PAUSED.
REQ-013 The block SHALL have port lap_data, output, 14 bits: {minutes, seconds} of the FIFO head entry.
REQ-014 The block SHALL have port lap_valid, output, 1 bit: the FIFO is non-empty.
REQ-015 The block SHALL have port lap_ready, input, 1 bit: the consumer accepts the head entry.
REQ-016 The block SHALL have port lap_count, output, clog2(LAP_DEPTH)+1 bits: FIFO occupancy.
REQ-017 The block SHALL have port lap_overflow, output, 1 bit: sticky flag, set when a lap hits a full FIFO.

Function
REQ-018 The FSM SHALL make these transitions on btn_ss: IDLE to RUNNING with sw_start; RUNNING to PAUSED with sw_stop; PAUSED to RUNNING with sw_start.
REQ-019 On btn_lr in RUNNING, the block SHALL capture {sw_minutes, sw_seconds} in the sampling cycle and push it to the FIFO on the next edge; the state is unchanged.
REQ-020 On btn_lr in PAUSED or IDLE, the block SHALL go to IDLE, pulse sw_reset, flush the FIFO and clear lap_overflow.
REQ-021 All pulses and state changes SHALL appear at the clock edge after the button is sampled, with 1-cycle latency; pulses are high for exactly one cycle.
REQ-022 If btn_ss and btn_lr are high in the same cycle, btn_ss SHALL be processed and btn_lr ignored.
REQ-023 A pop SHALL occur when lap_valid and lap_ready are both high at the edge.
REQ-024 lap_data SHALL be stable while lap_valid is high and lap_ready is low.
REQ-025 A simultaneous push and pop SHALL leave lap_count unchanged, including when the FIFO is full; lap_overflow is not set.
REQ-026 A flush SHALL take priority over a pop or push in the same cycle.
REQ-027 FIFO pointers SHALL wrap modulo LAP_DEPTH; lap_count saturates at LAP_DEPTH.
REQ-028 lap_valid SHALL be low whenever lap_count is 0.

Reset
REQ-029 When rst_n is low at an edge, the block SHALL set state to IDLE, sw_start, sw_stop and sw_reset to 0, lap_count to 0, lap_valid to 0, lap_overflow to 0 and lap_data to 0.
REQ-030 Reset SHALL override every input in the same cycle, including mid-operation; FIFO contents are discarded.

Configuration
REQ-031 With macro LAP_OVERWRITE_EN defined, a push to a full FIFO without a pop SHALL discard the oldest entry, store the new one, keep lap_count at LAP_DEPTH and set lap_overflow.
REQ-032 Without LAP_OVERWRITE_EN, a push to a full FIFO without a pop SHALL drop the new lap, leave the contents unchanged and set lap_overflow.

Verification
REQ-033 Scenario: reset, then btn_ss -> sw_start pulses 1 cycle later and state is 01; btn_ss again -> sw_stop pulses and state is 10.
REQ-034 Scenario: RUNNING, laps at 00:05, 01:10, 02:59 with lap_ready=0 -> lap_count=3, lap_data=0x005; then lap_ready=1 for 3 cycles -> outputs 0x005, 0x04A, 0x0BB in order, then lap_valid=0.
REQ-035 Scenario: RUNNING, 5 laps (values 1 to 5) with lap_ready=0 -> lap_overflow=1 and lap_count=4; head is 1 without the macro, 2 with it.
REQ-036 Scenario: full FIFO, btn_lr with lap_ready=1 in the same cycle -> lap_count stays 4 and lap_overflow stays 0.
REQ-037 Scenario: PAUSED with 2 laps stored, btn_lr -> sw_reset pulse, state 00, lap_count 0, lap_valid 0.
REQ-038 Scenario: RUNNING with btn_ss and btn_lr in the same cycle -> sw_stop pulse, no push; then rst_n=0 mid-drain -> all outputs return to reset values at the next edge.
